// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with programmable upper limit, wrap or saturate on
// boundary crossing, a step size and a prescaler that throttles advances.
module updown_mod_counter #(
  parameter int N = 8,
  parameter int S = 4,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] ld_val,
  input  logic         lim_we,
  input  logic [N-1:0] lim_val,
  input  logic         en,
  input  logic         dir,
  input  logic         sat,
  input  logic [S-1:0] step,
  input  logic [P-1:0] prescale,
  output logic [N-1:0] cnt,
  output logic         tc,
  output logic         ovf,
  output logic         msb
);

  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] lim_q, lim_d;
  logic [P-1:0] psc_q, psc_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;

  // Candidate next values are formed one bit wider so a carry or borrow
  // marks a crossing without any signed arithmetic.
  logic [N:0]   step_x;
  logic [N:0]   up_t;
  logic [N:0]   dn_t;
  logic         up_cross;
  logic         dn_cross;
  logic         adv;
  logic [N-1:0] ld_clamped;
  logic [N-1:0] lim_clamped;

  assign step_x      = {{(N + 1 - S){1'b0}}, step};
  assign up_t        = {1'b0, cnt_q} + step_x;
  assign dn_t        = {1'b0, cnt_q} - step_x;
  assign up_cross    = up_t > {1'b0, lim_q};
  assign dn_cross    = dn_t[N];
  assign adv         = en && (psc_q == prescale);
  assign ld_clamped  = (ld_val > lim_q) ? lim_q : ld_val;
  assign lim_clamped = (cnt_q > lim_val) ? lim_val : cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    psc_d = psc_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      psc_d = '0;
      ovf_d = 1'b0;
    end else if (ld) begin
      cnt_d = ld_clamped;
      psc_d = '0;
    end else if (lim_we) begin
      lim_d = lim_val;
      cnt_d = lim_clamped;
    end else if (en) begin
      if (adv) begin
        psc_d = '0;
        if (dir) begin
          if (up_cross) begin
            cnt_d = sat ? lim_q : '0;
            tc_d  = 1'b1;
            ovf_d = 1'b1;
          end else begin
            cnt_d = up_t[N-1:0];
          end
        end else begin
          if (dn_cross) begin
            cnt_d = sat ? '0 : lim_q;
            tc_d  = 1'b1;
            ovf_d = 1'b1;
          end else begin
            cnt_d = dn_t[N-1:0];
          end
        end
      end else begin
        psc_d = psc_q + P'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '1;
      psc_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      psc_q <= psc_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
  assign msb = cnt_q[N-1];

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: integer reference model checked every cycle,
// directed scenarios with literal expectations, then a short random phase.
module tb_updown_mod_counter;
  localparam int N = 8;
  localparam int S = 4;
  localparam int P = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr, ld, lim_we, en, dir, sat;
  logic [N-1:0] ld_val, lim_val;
  logic [S-1:0] step;
  logic [P-1:0] prescale;
  logic [N-1:0] cnt;
  logic         tc, ovf, msb;

  int checks   = 0;
  int failures = 0;

  updown_mod_counter #(.N(N), .S(S), .P(P)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val),
    .lim_we(lim_we), .lim_val(lim_val), .en(en), .dir(dir), .sat(sat),
    .step(step), .prescale(prescale), .cnt(cnt), .tc(tc), .ovf(ovf), .msb(msb)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_cnt, m_lim, m_psc, m_tc, m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_lim = (1 << N) - 1; m_psc = 0; m_tc = 0; m_ovf = 0;
    end else begin
      int t;
      m_tc = 0;
      if (clr) begin
        m_cnt = 0; m_psc = 0; m_ovf = 0;
      end else if (ld) begin
        m_cnt = (int'(ld_val) < m_lim) ? int'(ld_val) : m_lim;
        m_psc = 0;
      end else if (lim_we) begin
        m_lim = int'(lim_val);
        if (m_cnt > m_lim) m_cnt = m_lim;
      end else if (en) begin
        if (m_psc == int'(prescale)) begin
          m_psc = 0;
          t = dir ? m_cnt + int'(step) : m_cnt - int'(step);
          if (t >= 0 && t <= m_lim) begin
            m_cnt = t;
          end else begin
            m_tc = 1; m_ovf = 1;
            if (dir) m_cnt = sat ? m_lim : 0;
            else     m_cnt = sat ? 0 : m_lim;
          end
        end else begin
          m_psc = (m_psc + 1) % (1 << P);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic model_on = 1'b0;
  always @(negedge clk) begin
    if (model_on && !rst) begin
      chk("model_cnt", int'(cnt), m_cnt);
      chk("model_tc",  int'(tc),  m_tc);
      chk("model_ovf", int'(ovf), m_ovf);
      chk("model_msb", int'(msb), (m_cnt >> (N - 1)) & 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_cfg(input logic e, input logic d, input logic s,
                         input int st, input int ps);
    en = e; dir = d; sat = s; step = S'(st); prescale = P'(ps);
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic do_ld(input int v);
    ld = 1'b1; ld_val = N'(v); tick(); ld = 1'b0;
  endtask

  task automatic do_lim(input int v);
    lim_we = 1'b1; lim_val = N'(v); tick(); lim_we = 1'b0;
  endtask

  task automatic expect_out(input string name, input int c, input int t, input int o);
    chk({name, "_cnt"}, int'(cnt), c);
    chk({name, "_tc"},  int'(tc),  t);
    chk({name, "_ovf"}, int'(ovf), o);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clr = 1'b0; ld = 1'b0; lim_we = 1'b0; ld_val = '0; lim_val = '0;
    run_cfg(1'b0, 1'b1, 1'b0, 0, 0);
    tick(); tick();
    expect_out("reset", 0, 0, 0);
    chk("reset_msb", int'(msb), 0);
    rst = 1'b0;
    model_on = 1'b1;

    // Wrap up: L=9, step 3 -> 3,6,9,0
    do_lim(9);
    expect_out("wrap_lim", 0, 0, 0);
    run_cfg(1'b1, 1'b1, 1'b0, 3, 0);
    tick(); expect_out("wrap_e1", 3, 0, 0);
    tick(); expect_out("wrap_e2", 6, 0, 0);
    tick(); expect_out("wrap_e3", 9, 0, 0);
    tick(); expect_out("wrap_e4", 0, 1, 1);
    en = 1'b0;
    tick(); expect_out("wrap_hold", 0, 0, 1);

    // L=0: every nonzero advance crosses; step 0 never does
    do_lim(0);
    run_cfg(1'b1, 1'b1, 1'b0, 2, 0);
    tick(); expect_out("lim0_up", 0, 1, 1);
    step = '0;
    tick(); expect_out("lim0_step0", 0, 0, 1);
    en = 1'b0;

    // Saturate down from 5 with step 4 -> 1,0,0
    do_clr();
    expect_out("clr", 0, 0, 0);
    do_lim(255);
    do_ld(5);
    expect_out("sat_ld", 5, 0, 0);
    run_cfg(1'b1, 1'b0, 1'b1, 4, 0);
    tick(); expect_out("sat_e1", 1, 0, 0);
    tick(); expect_out("sat_e2", 0, 1, 1);
    tick(); expect_out("sat_e3", 0, 1, 1);
    en = 1'b0;

    // Prescale 2: advance on every 3rd enabled edge
    do_clr();
    run_cfg(1'b1, 1'b1, 1'b0, 1, 2);
    tick(); tick(); expect_out("psc_e2", 0, 0, 0);
    tick(); expect_out("psc_e3", 1, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    expect_out("psc_e9", 3, 0, 0);
    en = 1'b0;

    // Same run with en low for 2 edges after 4 enabled edges
    do_clr();
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    en = 1'b0;
    tick(); tick();
    expect_out("psc_gap", 1, 0, 0);
    en = 1'b1;
    tick(); expect_out("psc_g7", 1, 0, 0);
    tick(); expect_out("psc_g8", 2, 0, 0);
    tick(); tick(); expect_out("psc_g10", 2, 0, 0);
    tick(); expect_out("psc_g11", 3, 0, 0);
    en = 1'b0;

    // Priority: make ovf set first, then clr wins over ld and lim_we
    do_ld(255);
    run_cfg(1'b1, 1'b1, 1'b0, 1, 0);
    tick(); expect_out("pri_cross", 0, 1, 1);
    en = 1'b0;
    clr = 1'b1; ld = 1'b1; ld_val = 8'h40; lim_we = 1'b1; lim_val = 8'h20;
    tick(); clr = 1'b0;
    expect_out("pri_clr", 0, 0, 0);
    tick(); ld = 1'b0; lim_we = 1'b0;
    expect_out("pri_ld_bigL", 8'h40, 0, 0);
    do_lim(8'h20);
    expect_out("pri_clamp", 8'h20, 0, 0);
    ld = 1'b1; ld_val = 8'h40; lim_we = 1'b1; lim_val = 8'h30;
    tick(); ld = 1'b0; lim_we = 1'b0;
    expect_out("pri_ld_smallL", 8'h20, 0, 0);
    do_ld(8'h25);
    expect_out("pri_L_kept", 8'h20, 0, 0);

    // Limit shrink below the count
    do_lim(255);
    do_ld(200);
    do_lim(100);
    expect_out("shrink", 100, 0, 0);
    run_cfg(1'b1, 1'b1, 1'b0, 1, 0);
    tick(); expect_out("shrink_adv", 0, 1, 1);
    en = 1'b0;

    // Async reset mid-count while tc and ovf are high
    do_clr();
    do_lim(8'h7F);
    do_ld(8'h7F);
    run_cfg(1'b1, 1'b1, 1'b1, 1, 0);
    tick(); expect_out("pre_rst", 8'h7F, 1, 1);
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 0, 0, 0);
    chk("async_rst_msb", int'(msb), 0);
    en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); expect_out("post_rst", 0, 0, 0);
    do_ld(8'hFF);
    expect_out("post_rst_L", 8'hFF, 0, 0);
    chk("post_rst_msb", int'(msb), 1);

    // Random phase, checked by the per-cycle model compare
    for (int i = 0; i < 400; i++) begin
      clr    = ($urandom_range(0, 40) == 0);
      ld     = ($urandom_range(0, 15) == 0);
      lim_we = ($urandom_range(0, 20) == 0);
      ld_val = N'($urandom_range(0, 255));
      lim_val = N'($urandom_range(0, 255));
      run_cfg($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 2));
      tick();
    end
    clr = 1'b0; ld = 1'b0; lim_we = 1'b0; en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
